// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM encoding, watchdog width and a constant clog2.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    GRANT        = 2'b01,
    WAIT_MEM_LOW = 2'b10
  } arbState_t;

  localparam int ARB_WDOG_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req[N], ptr[OW] in; found, idx[OW] out.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          found,
  output logic [OW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [OW-1:0]  off;
  logic [OW:0]    sum;

  always_comb begin
    dbl   = {req, req};
    // rotate so that bit 0 of rot is req[ptr]
    rot   = N'(dbl >> ptr);
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = OW'(i);
      end
    end
    // un-rotate: (ptr + off) mod N
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (OW + 1)'(N)) begin
      sum = sum - (OW + 1)'(N);
    end
    idx = sum[OW-1:0];
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared memory bus with grant watchdog.
// Ports: clk, reset, rq[N], mem_ready in; grant, owner, owner_valid, timeout_err out.
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int OW = (N_MASTERS > 1) ? clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] rq,
  input  logic                 mem_ready,
  output logic [N_MASTERS-1:0] grant,
  output logic [OW-1:0]        owner,
  output logic                 owner_valid,
  output logic                 timeout_err
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [ARB_WDOG_W-1:0] WDOG_LAST =
    ARB_WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_MASTERS - 1);

  arbState_t              state;
  logic [OW-1:0]          ptr;
  logic [ARB_WDOG_W-1:0]  wdogCnt;
  logic                   pickFound;
  logic [OW-1:0]          pickIdx;
  logic [N_MASTERS-1:0]   pickOneHot;
  logic                   ownerRq;
  logic                   wdogHit;
  logic [OW-1:0]          nextPtr;

  rr_priority_picker #(
    .N  (N_MASTERS),
    .OW (OW)
  ) uPick (
    .req   (rq),
    .ptr   (ptr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  always_comb begin
    ownerRq    = 1'b0;
    pickOneHot = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner == OW'(i)) ownerRq = rq[i];
      if (pickIdx == OW'(i)) pickOneHot[i] = 1'b1;
    end
  end

  // wraps to 0; with one master this is always 0
  assign nextPtr = (owner == LAST_IDX) ? '0 : owner + OW'(1);
  assign wdogHit = WDOG_EN && (wdogCnt == WDOG_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      wdogCnt     <= '0;
      grant       <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pickFound && !mem_ready) begin
            state       <= GRANT;
            grant       <= pickOneHot;
            owner       <= pickIdx;
            owner_valid <= 1'b1;
            wdogCnt     <= '0;
          end
        end
        GRANT: begin
          if (wdogCnt != '1) begin
            wdogCnt <= wdogCnt + 1'b1;
          end
          // release has priority over a coincident timeout
          if (!ownerRq || wdogHit) begin
            state       <= WAIT_MEM_LOW;
            grant       <= '0;
            owner_valid <= 1'b0;
            ptr         <= nextPtr;
            timeout_err <= ownerRq;
          end
        end
        WAIT_MEM_LOW: begin
          if (!mem_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          owner_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (N=4, watchdog 8).
// Directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  rq = '0;
  logic          mem_ready = 1'b0;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          owner_valid;
  logic          timeout_err;

  int nCmp = 0;
  int nFail = 0;
  bit chkEn = 1'b0;

  bus_arbiter_rr #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rq          (rq),
    .mem_ready   (mem_ready),
    .grant       (grant),
    .owner       (owner),
    .owner_valid (owner_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idxOf(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural model: who holds the bus, how long, whether the bus
  // still has to see mem_ready low before anyone new can be picked.
  int mOwner = 0;
  int mPtr = 0;
  int mHeld = 0;
  bit mValid = 0;
  bit mDrain = 0;
  bit mTerr = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mOwner = 0; mPtr = 0; mHeld = 0;
      mValid = 0; mDrain = 0; mTerr = 0;
    end else begin
      mTerr = 0;
      if (mValid) begin
        mHeld++;
        if (!rq[mOwner]) begin
          mValid = 0; mDrain = 1; mPtr = (mOwner + 1) % N;
        end else if (T != 0 && mHeld == T) begin
          mValid = 0; mDrain = 1; mPtr = (mOwner + 1) % N;
          mTerr = 1;
        end
      end else if (mDrain) begin
        if (!mem_ready) mDrain = 0;
      end else if (rq != 0 && !mem_ready) begin
        for (int k = 0; k < N; k++) begin
          if (rq[(mPtr + k) % N]) begin
            mOwner = (mPtr + k) % N;
            mValid = 1;
            mHeld = 0;
            break;
          end
        end
      end
    end
  end

  function automatic logic [N-1:0] expGrant();
    logic [N-1:0] g;
    g = '0;
    if (mValid) g[mOwner] = 1'b1;
    return g;
  endfunction

  always @(negedge clk) begin
    if (chkEn && !reset) begin
      check("m_grant", grant, expGrant());
      check("m_owner", owner, mOwner);
      check("m_valid", owner_valid, mValid);
      check("m_terr", timeout_err, mTerr);
    end
  end

  initial begin
    int order[$];
    int gaps[$];
    int cnt;
    int gap;
    int held;

    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_owner", owner, 0);
    check("rst_valid", owner_valid, 0);
    check("rst_terr", timeout_err, 0);
    reset = 1'b0;
    chkEn = 1'b1;

    // fairness: all request, each drops for one cycle after 3 granted
    cnt = 0; gap = 0;
    rq = '1;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      @(negedge clk);
      rq = '1;
      if (grant != 0) begin
        if (cnt == 0) begin
          order.push_back(idxOf(grant));
          gaps.push_back(gap);
        end
        cnt++; gap = 0;
        if (cnt == 3) rq[idxOf(grant)] = 1'b0;
      end else begin
        cnt = 0; gap++;
      end
    end
    check("fair_count", order.size(), 5);
    foreach (order[i]) check("fair_order", order[i], i % N);
    for (int i = 1; i < gaps.size(); i++) check("fair_gap", gaps[i], 2);
    rq = '0;
    repeat (3) @(negedge clk);

    // single request
    rq = 4'b0100;
    @(negedge clk);
    check("single_grant", grant, 4'b0100);
    check("single_owner", owner, 2);
    check("single_valid", owner_valid, 1);
    repeat (4) @(negedge clk);
    rq = '0;
    @(negedge clk);
    check("single_rel", grant, 0);
    check("single_rel_valid", owner_valid, 0);
    check("single_keep_owner", owner, 2);
    check("model_ptr", mPtr, 3);
    repeat (2) @(negedge clk);

    // wrap and skip
    rq = 4'b0011;
    @(negedge clk);
    check("wrap_g0", grant, 4'b0001);
    rq = 4'b0010;
    @(negedge clk);
    check("wrap_gap1", grant, 0);
    @(negedge clk);
    check("wrap_gap2", grant, 0);
    @(negedge clk);
    check("skip_g1", grant, 4'b0010);
    rq = 4'b1000;
    @(negedge clk);
    check("skip_rel", grant, 0);
    @(negedge clk);
    @(negedge clk);
    check("skip_g3", grant, 4'b1000);
    check("skip_o3", owner, 3);

    // memory busy hold-off
    rq = 4'b0010;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_hold", grant, 0);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("busy_gap", grant, 0);
    @(negedge clk);
    check("busy_g1", grant, 4'b0010);
    rq = '0;
    repeat (3) @(negedge clk);

    // watchdog revoke, then a different requester
    rq = 4'b0001;
    @(negedge clk);
    check("wd_g0", grant, 4'b0001);
    rq = 4'b0011;
    held = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant[0]) held++;
      else break;
    end
    check("wd_held", held, T);
    check("wd_terr", timeout_err, 1);
    @(negedge clk);
    check("wd_terr_pulse", timeout_err, 0);
    check("wd_gap", grant, 0);
    @(negedge clk);
    check("wd_next", grant, 4'b0010);
    rq = '0;
    repeat (3) @(negedge clk);

    // release coincides with timeout
    rq = 4'b0001;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant[0]) begin
        held++;
        if (held == T) rq = '0;
      end else if (held > 0) begin
        break;
      end
    end
    check("same_held", held, T);
    check("same_grant", grant, 0);
    check("same_terr", timeout_err, 0);
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a grant
    rq = 4'b0100;
    @(negedge clk);
    check("ar_g2", grant, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("ar_grant", grant, 0);
    check("ar_owner", owner, 0);
    check("ar_valid", owner_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    rq = 4'b1010;
    @(negedge clk);
    check("ar_first", grant, 4'b0010);
    check("ar_first_o", owner, 1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      mem_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1;
        check("rnd_rst_grant", grant, 0);
        check("rnd_rst_valid", owner_valid, 0);
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin arbiter sharing one memory bus (data or instruction) between `N_MASTERS` cores, each connected through its own arbitration submodule via a request/grant pair. Issues at most one one-hot grant and holds it until the owner drops its request. It does not re-arbitrate until the bus memory has deasserted ready. A watchdog revokes grants held past a programmable limit.

## Interface
- `N_MASTERS`, 4: number of requesting cores, 1..16.
- `TIMEOUT_CYCLES`, 0: maximum cycles one grant may be held, 1..65535; 0 disables the watchdog.
- `OW`, derived: owner index width, max(1, clog2(`N_MASTERS`)).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rq`  in  N_MASTERS  per-core bus request (`D_Bus_RQ` / `I_Bus_RQ` of each submodule).
- `mem_ready`  in  1  bus memory ready (`Bus_*Mem_Ready`).
- `grant`  out  N_MASTERS  one-hot or zero, per-core `*_Bus_GRANT`; registered.
- `owner`  out  OW  index of the current or last grantee; registered.
- `owner_valid`  out  1  high while `grant` is nonzero.
- `timeout_err`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- **Reset values:**
  - `grant`=0, `owner`=0, `owner_valid`=0, `timeout_err`=0.
  - State IDLE, round-robin pointer `ptr`=0, watchdog counter=0.
- **States:** IDLE, GRANT, WAIT_MEM_LOW.
- **IDLE:**
  - `grant`=0.
  - If `rq`≠0 and `mem_ready`=0, the winner is the first set `rq` bit searching from `ptr` upward, wrapping at N_MASTERS-1→0.
  - Next state GRANT; `grant[winner]`=1, `owner`=winner, `owner_valid`=1, counter cleared.
  - If `mem_ready`=1, no grant is issued; the arbiter stays in IDLE.
- **GRANT:**
  - `grant` is held.
  - The counter increments each cycle, saturating at 65535.
  - `rq` bits of non-owners are ignored.
  - **Owner release:** `rq[owner]`=0 sampled → `grant`=0, `owner_valid`=0, `ptr`=(owner+1) mod N_MASTERS, next state WAIT_MEM_LOW.
  - **Watchdog:** if TIMEOUT_CYCLES≠0 and the counter = TIMEOUT_CYCLES-1 while `rq[owner]`=1 → same actions as owner release, plus `timeout_err`=1 for one cycle.
  - If release and timeout occur on the same edge, release wins and `timeout_err` stays 0.
- **WAIT_MEM_LOW:**
  - `grant`=0.
  - `mem_ready`=0 → IDLE; otherwise stay.
  - No grant is issued from this state.
- `owner` keeps the last grantee after release and changes only when a new grant is issued.
- **N_MASTERS=1:** `ptr` is constant 0; the other rules are unchanged.
- **Reset mid-GRANT:** `grant` drops asynchronously and all state returns to reset values.

## Timing
- **Grant latency:**
  - Edge k samples `rq`≠0 in IDLE with `mem_ready`=0 → `grant` high after edge k.
  - A request raised from IDLE sees its grant on the first edge after the request.
- **Release latency:** `rq[owner]` low sampled at edge r → `grant` low after edge r.
- **Re-arbitration gap:**
  - If `mem_ready` is already low: WAIT_MEM_LOW after r, IDLE after r+1, next grant after r+2.
  - Minimum 2 grant-free cycles between grants.
- **Watchdog:** the grant is issued at edge g and revoked at edge g+TIMEOUT_CYCLES, so it is held for exactly TIMEOUT_CYCLES cycles.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package `arb_pkg`:**
  - State encoding: IDLE=2'b00, GRANT=2'b01, WAIT_MEM_LOW=2'b10; 2'b11 → IDLE.
  - Constant `ARB_WDOG_W`=16.
  - Function `clog2`.
- **Sub-module `rr_priority_picker`:**
  - Purely combinational.
  - Inputs `req[N]` and `ptr[OW]`.
  - Outputs `found` and `idx[OW]`.
  - Implementation: rotate by `ptr`, priority-encode, un-rotate.
- Top level: the FSM, `ptr`, watchdog counter and output registers.

## Test plan
- **Single request:** N=4, `mem_ready`=0. `rq`=4'b0100 raised before edge 3 → `grant`=4'b0100 and `owner`=2 after edge 3. `rq` dropped at edge 8 → `grant`=0 after edge 8; `ptr`=3.
- **Round-robin fairness:** `rq`=4'b1111 held; each owner drops `rq` for one cycle after 3 cycles of grant, then re-raises it. Grant order is 0,1,2,3,0, with exactly 2 grant-free cycles between consecutive grants.
- **Wrap and skip:** `ptr`=3 and `rq`=4'b0011 → grant to 0, then to 1; `rq`=4'b1000 alone → grant to 3.
- **Memory-busy hold-off:** hold `mem_ready`=1 for 5 cycles after a release while `rq`=4'b0010. `grant` stays 0 throughout; the grant to 1 comes 2 edges after `mem_ready` falls.
- **Watchdog:** TIMEOUT_CYCLES=8, `rq[0]` held high. `grant[0]` is held for exactly 8 cycles, then `timeout_err` pulses one cycle and the next grant goes to a different requester if one exists. Variant with `rq[0]` dropping on the same edge as the timeout → no `timeout_err`.
- **Async reset:** assert `reset` mid-GRANT, between clock edges. `grant`, `owner_valid` and `owner` are 0 immediately; the first grant after reset is chosen from `ptr`=0.
